// File: rtl/instruction_loader_pkg.sv
// Shared pipeline definitions: loader FSM encoding and the HALT instruction.
// Also used by the decode/control stages to recognise the terminating word.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] HALT_WORD_C = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Big-endian 4-byte shift register with byte index; pulses o_word_valid
// combinationally on the byte that completes a word.
// Ports: i_clk, i_reset, i_clear (drop partial word), i_byte_en/i_byte (input
// byte strobe/data), o_word (assembled word), o_word_valid (4th byte seen).
module instruction_loader_byte_assembler #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_byte_en,
  input  logic [7:0]   i_byte,
  output logic [W-1:0] o_word,
  output logic         o_word_valid
);

  logic [W-1:0] word_q, word_d;
  logic [1:0]   idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (i_clear) begin
      idx_d = '0;
    end else if (i_byte_en) begin
      word_d = {word_q[W-9:0], i_byte};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = i_byte_en && !i_clear && (idx_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Program loader: UART bytes -> 32-bit words -> instruction memory writes.
// Ports: i_clk, i_reset (sync, active-high), i_start, i_rx_data/i_rx_done;
// outputs o_instruction_write, o_address_memory_ins, o_instruction, o_busy,
// o_load_done, o_overflow, o_word_count, o_checksum.
// Optional: define LOADER_CHECKSUM_EN to keep a running XOR of written words.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int            NB        = 32,
  parameter int            TAM_I     = 256,
  parameter logic [NB-1:0] HALT_WORD = NB'(HALT_WORD_C),
  localparam int           CW        = $clog2(TAM_I) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_done,
  output logic          o_instruction_write,
  output logic [NB-1:0] o_address_memory_ins,
  output logic [NB-1:0] o_instruction,
  output logic          o_busy,
  output logic          o_load_done,
  output logic          o_overflow,
  output logic [CW-1:0] o_word_count,
  output logic [NB-1:0] o_checksum
);

  state_e        state_q, state_d;
  logic [NB-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [NB-1:0] word;
  logic          word_valid;
  logic          clear;
  logic          cont;
  logic          accept;

  // cont: the word in WRITE is neither HALT nor the last slot of memory.
  assign cont   = (word != HALT_WORD) &&
                  (cnt_q + CW'(1) != CW'(TAM_I));
  // A byte arriving during WRITE starts the next word only if loading goes on.
  assign accept = i_rx_done &&
                  ((state_q == RECV) || (state_q == WRITE && cont));
  assign clear  = i_start &&
                  ((state_q == IDLE) || (state_q == DONE));

  instruction_loader_byte_assembler #(
    .W (NB)
  ) u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (clear),
    .i_byte_en    (accept),
    .i_byte       (i_rx_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = RECV;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RECV: begin
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q + CW'(1);
        if (word == HALT_WORD) begin
          state_d = DONE;
        end else if (!cont) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = RECV;
          addr_d  = addr_q + NB'(4);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [NB-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clear) chk_d = '0;
    else if (state_q == WRITE) chk_d = chk_q ^ word;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) chk_q <= '0;
    else         chk_q <= chk_d;
  end

  assign o_checksum = chk_q;
`else
  assign o_checksum = '0;
`endif

  assign o_instruction_write  = (state_q == WRITE);
  assign o_address_memory_ins = addr_q;
  assign o_instruction        = word;
  assign o_busy               = (state_q == RECV) || (state_q == WRITE);
  assign o_load_done          = (state_q == DONE);
  assign o_overflow           = ovf_q;
  assign o_word_count         = cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: DUT A (TAM_I=256) and DUT B (TAM_I=4)
// driven from one byte stream, routed by sel, against a word-level model.
module tb_instruction_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rx_done = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  logic        wr_a, busy_a, done_a, ovf_a;
  logic [31:0] addr_a, ins_a, chk_a;
  logic [8:0]  cnt_a;
  logic        wr_b, busy_b, done_b, ovf_b;
  logic [31:0] addr_b, ins_b, chk_b;
  logic [2:0]  cnt_b;

  instruction_loader #(.NB(32), .TAM_I(256)) dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_start(start & ~sel), .i_rx_data(rx_data),
    .i_rx_done(rx_done & ~sel),
    .o_instruction_write(wr_a), .o_address_memory_ins(addr_a),
    .o_instruction(ins_a), .o_busy(busy_a), .o_load_done(done_a),
    .o_overflow(ovf_a), .o_word_count(cnt_a), .o_checksum(chk_a)
  );

  instruction_loader #(.NB(32), .TAM_I(4)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_start(start & sel), .i_rx_data(rx_data),
    .i_rx_done(rx_done & sel),
    .o_instruction_write(wr_b), .o_address_memory_ins(addr_b),
    .o_instruction(ins_b), .o_busy(busy_b), .o_load_done(done_b),
    .o_overflow(ovf_b), .o_word_count(cnt_b), .o_checksum(chk_b)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model: one entry per DUT
  int          m_tam [2] = '{256, 4};
  bit          m_act [2];
  logic [31:0] m_part[2];
  int          m_nb  [2];
  int          m_cnt [2];
  logic [31:0] m_chk [2];
  bit          m_ovf [2];
  bit          m_done[2];

  logic [63:0] expA[$], expB[$], obsA[$], obsB[$];
  logic [7:0]  stim[$];
  int          dblA = 0, dblB = 0;
  logic        pw_a = 1'b0, pw_b = 1'b0;

  always @(negedge clk) begin
    if (wr_a) obsA.push_back({addr_a, ins_a});
    if (wr_b) obsB.push_back({addr_b, ins_b});
    if (wr_a && pw_a) dblA++;
    if (wr_b && pw_b) dblB++;
    pw_a = wr_a;
    pw_b = wr_b;
  end

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_part[d] = '0; m_nb[d] = 0;
      m_cnt[d] = 0; m_chk[d] = '0; m_ovf[d] = 0; m_done[d] = 0;
    end
  endfunction

  function automatic void model_start(int d);
    if (!m_act[d]) begin
      m_act[d] = 1; m_nb[d] = 0; m_cnt[d] = 0;
      m_chk[d] = '0; m_ovf[d] = 0; m_done[d] = 0;
    end
  endfunction

  function automatic void model_byte(int d, logic [7:0] b);
    logic [63:0] e;
    if (!m_act[d]) return;
    m_part[d] = {m_part[d][23:0], b};
    m_nb[d]++;
    if (m_nb[d] == 4) begin
      m_nb[d] = 0;
      e = {32'(m_cnt[d] * 4), m_part[d]};
      if (d == 0) expA.push_back(e);
      else        expB.push_back(e);
      m_chk[d] ^= m_part[d];
      m_cnt[d]++;
      if (m_part[d] == HALT) begin
        m_act[d] = 0; m_done[d] = 1;
      end else if (m_cnt[d] == m_tam[d]) begin
        m_act[d] = 0; m_done[d] = 1; m_ovf[d] = 1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_chk(int d);
`ifdef LOADER_CHECKSUM_EN
    return m_chk[d];
`else
    return 32'h0;
`endif
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    expA.delete(); expB.delete(); obsA.delete(); obsB.delete();
    dblA = 0; dblB = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    model_start(int'(sel));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_word(logic [31:0] w);
    stim.push_back(w[31:24]); stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);  stim.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic send_stim(int gap);
    foreach (stim[i]) begin
      @(negedge clk);
      rx_data = stim[i];
      rx_done = 1'b1;
      model_byte(int'(sel), stim[i]);
      if (gap > 0) begin
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_done = 1'b0;
    stim.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    model_reset();
    idle(1);
    n_checks++;
    if ({wr_a, busy_a, done_a, ovf_a, addr_a, ins_a, chk_a, cnt_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got wr=%b busy=%b done=%b ovf=%b addr=%h ins=%h chk=%h cnt=%0d, want all 0",
               wr_a, busy_a, done_a, ovf_a, addr_a, ins_a, chk_a, cnt_a);
    end
    n_checks++;
    if ({wr_b, busy_b, done_b, ovf_b, addr_b, ins_b, chk_b, cnt_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got wr=%b busy=%b done=%b ovf=%b addr=%h ins=%h cnt=%0d, want all 0",
               wr_b, busy_b, done_b, ovf_b, addr_b, ins_b, cnt_b);
    end
    push_word(32'h1234_5678);
    send_stim(1);
    idle(3);
    n_checks++;
    if (obsA.size() !== 0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bytes: got writes=%0d busy=%b, want 0 0", obsA.size(), busy_a);
    end
  endtask

  task automatic test_basic();
    do_reset();
    sel = 1'b0;
    pulse_start();
    push_word(32'h2001_0005);
    push_word(HALT);
    send_stim(2);
    idle(4);
    n_checks++;
    if (obsA.size() !== expA.size() || obsA.size() !== 2) begin
      n_fail++;
      $display("FAIL basic_nwrites: got %0d, want 2", obsA.size());
    end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      n_checks++;
      if (obsA[i] !== expA[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %h, want %h", i, obsA[i], expA[i]);
      end
    end
    n_checks++;
    if (obsA.size() > 0 && obsA[0] !== {32'd0, 32'h2001_0005}) begin
      n_fail++;
      $display("FAIL basic_first: got %h, want 20010005 @0", obsA[0]);
    end
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_flags: got done=%b busy=%b ovf=%b, want 1 0 0", done_a, busy_a, ovf_a);
    end
    n_checks++;
    if (cnt_a !== 9'd2) begin
      n_fail++;
      $display("FAIL basic_count: got %0d, want 2", cnt_a);
    end
    n_checks++;
`ifdef LOADER_CHECKSUM_EN
    if (chk_a !== 32'hDFFE_FFFA) begin
      n_fail++;
      $display("FAIL basic_checksum: got %h, want dffefffa", chk_a);
    end
`else
    if (chk_a !== exp_chk(0)) begin
      n_fail++;
      $display("FAIL basic_checksum: got %h, want %h", chk_a, exp_chk(0));
    end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    sel = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) push_word(rand_word());
    stim.push_back(8'($urandom_range(0, 255)));
    send_stim(1);
    idle(4);
    n_checks++;
    if (obsB.size() !== 4 || expB.size() !== 4) begin
      n_fail++;
      $display("FAIL ovf_nwrites: got %0d, want 4", obsB.size());
    end
    for (int i = 0; i < expB.size() && i < obsB.size(); i++) begin
      n_checks++;
      if (obsB[i] !== expB[i] || obsB[i][63:32] !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL ovf_write%0d: got %h, want %h", i, obsB[i], expB[i]);
      end
    end
    n_checks++;
    if (ovf_b !== 1'b1 || done_b !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flags: got ovf=%b done=%b busy=%b, want 1 1 0", ovf_b, done_b, busy_b);
    end
    n_checks++;
    if (cnt_b !== 3'(m_cnt[1]) || chk_b !== exp_chk(1)) begin
      n_fail++;
      $display("FAIL ovf_count: got cnt=%0d chk=%h, want %0d %h", cnt_b, chk_b, m_cnt[1], exp_chk(1));
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel = 1'b0;
    pulse_start();
    stim.push_back(8'hA5);
    stim.push_back(8'h3C);
    send_stim(1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    n_checks++;
    if (obsA.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_write: got %0d writes, want 0", obsA.size());
    end
    n_checks++;
    if ({busy_a, done_a, ovf_a, addr_a, ins_a, chk_a, cnt_a} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b addr=%h ins=%h cnt=%0d, want 0",
               busy_a, addr_a, ins_a, cnt_a);
    end
    pulse_start();
    push_word(rand_word());
    send_stim(1);
    idle(3);
    n_checks++;
    if (obsA.size() !== 1 || expA.size() !== 1 || obsA[0] !== expA[0]) begin
      n_fail++;
      $display("FAIL midreset_reload: got n=%0d w=%h, want 1 %h",
               obsA.size(), obsA.size() > 0 ? obsA[0] : 64'h0, expA[0]);
    end
    n_checks++;
    if (busy_a !== 1'b1 || cnt_a !== 9'd1) begin
      n_fail++;
      $display("FAIL midreset_state: got busy=%b cnt=%0d, want 1 1", busy_a, cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) push_word(rand_word());
    push_word(HALT);
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    send_stim(0);
    idle(5);
    n_checks++;
    if (obsA.size() !== expA.size() || expA.size() !== 7) begin
      n_fail++;
      $display("FAIL b2b_nwrites: got %0d, want 7", obsA.size());
    end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      n_checks++;
      if (obsA[i] !== expA[i]) begin
        n_fail++;
        $display("FAIL b2b_write%0d: got %h, want %h", i, obsA[i], expA[i]);
      end
    end
    n_checks++;
    if (dblA !== 0) begin
      n_fail++;
      $display("FAIL b2b_strobe: got %0d consecutive strobes, want 0", dblA);
    end
    n_checks++;
    if (cnt_a !== 9'(m_cnt[0]) || done_a !== 1'b1 || chk_a !== exp_chk(0)) begin
      n_fail++;
      $display("FAIL b2b_final: got cnt=%0d done=%b chk=%h, want %0d 1 %h",
               cnt_a, done_a, chk_a, m_cnt[0], exp_chk(0));
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w;
    do_reset();
    sel = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      w = rand_word();
      stim.push_back(w[31:24]);
      stim.push_back(w[23:16]);
      send_stim(1);
      pulse_start();
      stim.push_back(w[15:8]);
      stim.push_back(w[7:0]);
      send_stim(1);
      pulse_start();
    end
    push_word(HALT);
    send_stim(1);
    idle(4);
    n_checks++;
    if (obsA.size() !== expA.size() || expA.size() !== 5) begin
      n_fail++;
      $display("FAIL startign_nwrites: got %0d, want 5", obsA.size());
    end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      n_checks++;
      if (obsA[i] !== expA[i]) begin
        n_fail++;
        $display("FAIL startign_write%0d: got %h, want %h", i, obsA[i], expA[i]);
      end
    end
  endtask

  task automatic test_restart();
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_pre: got done=%b, want 1", done_a);
    end
    expA.delete();
    obsA.delete();
    sel = 1'b0;
    pulse_start();
    n_checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1 || cnt_a !== 9'd0 ||
        chk_a !== 32'h0 || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got done=%b busy=%b cnt=%0d chk=%h ovf=%b, want 0 1 0 0 0",
               done_a, busy_a, cnt_a, chk_a, ovf_a);
    end
    push_word(rand_word());
    push_word(rand_word());
    push_word(HALT);
    send_stim(1);
    idle(4);
    n_checks++;
    if (obsA.size() !== 3 || expA.size() !== 3) begin
      n_fail++;
      $display("FAIL restart_nwrites: got %0d, want 3", obsA.size());
    end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      n_checks++;
      if (obsA[i] !== expA[i]) begin
        n_fail++;
        $display("FAIL restart_write%0d: got %h, want %h", i, obsA[i], expA[i]);
      end
    end
    n_checks++;
    if (cnt_a !== 9'd3 || done_a !== 1'b1 || chk_a !== exp_chk(0)) begin
      n_fail++;
      $display("FAIL restart_final: got cnt=%0d done=%b chk=%h, want 3 1 %h",
               cnt_a, done_a, chk_a, exp_chk(0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_start_ignored();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
